// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// UART receiver (8N1, LSB first, idle-high line) with its own oversampling tick
// generator. Delivers framed bytes to the Debug unit via a sticky ready flag.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_rx           serial line, asynchronous to i_clk, idles high
//   i_rx_clear     clears o_rx_ready / o_rx_overrun
//   o_rx_data      last correctly framed byte, stable while o_rx_ready=1
//   o_rx_ready     sticky byte-available flag
//   o_rx_frame_err one-cycle pulse when the sampled stop bit is 0
//   o_rx_overrun   sticky; a byte completed while o_rx_ready was already set
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_sampler #(
   parameter int CLK_FR      = 50000000,
   parameter int BAUD_RATE   = 9600,
   parameter int RX_DIV_SAMP = 16,
   parameter int DBIT        = 8,
   parameter int SB_TICK     = 16
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_rx,
   input  logic            i_rx_clear,
   output logic [DBIT-1:0] o_rx_data,
   output logic            o_rx_ready,
   output logic            o_rx_frame_err,
   output logic            o_rx_overrun
);

   localparam int DIV  = CLK_FR / (BAUD_RATE * RX_DIV_SAMP);
   localparam int TW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SMAX = (SB_TICK > RX_DIV_SAMP) ? SB_TICK : RX_DIV_SAMP;
   localparam int SW   = $clog2(SMAX);
   localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
   localparam logic [SW-1:0] S_HALF    = SW'(RX_DIV_SAMP / 2 - 1);
   localparam logic [SW-1:0] S_LAST    = SW'(RX_DIV_SAMP - 1);
   localparam logic [SW-1:0] S_STOP    = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

   logic [TW-1:0]   r_tick_cnt;
   logic            w_tick;
   logic [1:0]      r_sync;
   logic            w_rx_s;

   state_t          r_state,  w_state_nx;
   logic [SW-1:0]   r_s_cnt,  w_s_cnt_nx;
   logic [NW-1:0]   r_n_cnt,  w_n_cnt_nx;
   logic [DBIT-1:0] r_shift,  w_shift_nx;
   logic            w_done;
   logic            w_ferr;

   logic [DBIT-1:0] r_data;
   logic            r_ready;
   logic            r_ferr;
   logic            r_ovr;

   // Free-running oversampling tick; independent of the FSM so frame
   // alignment only costs at most one tick period of phase error.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)     r_tick_cnt <= '0;
      else if (w_tick) r_tick_cnt <= '0;
      else             r_tick_cnt <= r_tick_cnt + 1'b1;
   end
   assign w_tick = (r_tick_cnt == TICK_LAST);

   // Two-flop synchroniser, preset to idle level so reset never looks like a start bit.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_sync <= 2'b11;
      else         r_sync <= {r_sync[0], i_rx};
   end
   assign w_rx_s = r_sync[1];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_s_cnt <= '0;
         r_n_cnt <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nx;
         r_s_cnt <= w_s_cnt_nx;
         r_n_cnt <= w_n_cnt_nx;
         r_shift <= w_shift_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_s_cnt_nx = r_s_cnt;
      w_n_cnt_nx = r_n_cnt;
      w_shift_nx = r_shift;
      w_done     = 1'b0;
      w_ferr     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Start detection is not tick-gated to keep back-to-back frames gap-free.
            if (!w_rx_s) begin
               w_state_nx = ST_START;
               w_s_cnt_nx = '0;
            end
         end
         ST_START: begin
            if (w_tick) begin
               if (r_s_cnt == S_HALF) begin
                  if (!w_rx_s) begin
                     w_state_nx = ST_DATA;
                     w_s_cnt_nx = '0;
                     w_n_cnt_nx = '0;
                  end else begin
                     w_state_nx = ST_IDLE;   // glitch shorter than half a bit
                  end
               end else begin
                  w_s_cnt_nx = r_s_cnt + 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               if (r_s_cnt == S_LAST) begin
                  w_s_cnt_nx = '0;
                  w_shift_nx = {w_rx_s, r_shift[DBIT-1:1]};
                  if (r_n_cnt == N_LAST) w_state_nx = ST_STOP;
                  else                   w_n_cnt_nx = r_n_cnt + 1'b1;
               end else begin
                  w_s_cnt_nx = r_s_cnt + 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (w_tick) begin
               if (r_s_cnt == S_STOP) begin
                  w_state_nx = ST_IDLE;
                  if (w_rx_s) w_done = 1'b1;
                  else        w_ferr = 1'b1;
               end else begin
                  w_s_cnt_nx = r_s_cnt + 1'b1;
               end
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   // Completion takes priority over a simultaneous clear; a clear in the
   // completion cycle still suppresses the overrun flag.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_data  <= '0;
         r_ready <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_ferr <= w_ferr;
         if (w_done) begin
            r_data  <= r_shift;
            r_ready <= 1'b1;
            if (i_rx_clear)   r_ovr <= 1'b0;
            else if (r_ready) r_ovr <= 1'b1;
         end else if (i_rx_clear) begin
            r_ready <= 1'b0;
            r_ovr   <= 1'b0;
         end
      end
   end

   assign o_rx_data      = r_data;
   assign o_rx_ready     = r_ready;
   assign o_rx_frame_err = r_ferr;
   assign o_rx_overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_sampler
// Directed bench for uart_rx_sampler. The baud setup is scaled down
// (DIV=10, 160 clocks per bit) to keep frames short.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx_sampler;

   localparam int CLK_FR      = 1600000;
   localparam int BAUD_RATE   = 10000;
   localparam int RX_DIV_SAMP = 16;
   localparam int DBIT        = 8;
   localparam int SB_TICK     = 16;
   localparam int DIV         = CLK_FR / (BAUD_RATE * RX_DIV_SAMP);
   localparam int BIT         = DIV * RX_DIV_SAMP;
   localparam int LAT_NOM     = 9 * BIT + BIT / 2;   // start of frame to mid stop bit
   localparam int LAT_TOL     = DIV + 2;

   logic            i_clk = 1'b0;
   logic            i_reset = 1'b1;
   logic            i_rx = 1'b1;
   logic            i_rx_clear = 1'b0;
   logic [DBIT-1:0] o_rx_data;
   logic            o_rx_ready;
   logic            o_rx_frame_err;
   logic            o_rx_overrun;

   uart_rx_sampler #(
      .CLK_FR      (CLK_FR),
      .BAUD_RATE   (BAUD_RATE),
      .RX_DIV_SAMP (RX_DIV_SAMP),
      .DBIT        (DBIT),
      .SB_TICK     (SB_TICK)
   ) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_rx           (i_rx),
      .i_rx_clear     (i_rx_clear),
      .o_rx_data      (o_rx_data),
      .o_rx_ready     (o_rx_ready),
      .o_rx_frame_err (o_rx_frame_err),
      .o_rx_overrun   (o_rx_overrun)
   );

   always #5 i_clk = ~i_clk;

   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   rdy_rises = 0;
   int   rise_cyc = 0;
   int   ferr_cyc = 0;
   logic prev_rdy = 1'b0;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Observes outputs mid-cycle: counts ready rising edges and frame-error cycles.
   always @(negedge i_clk) begin
      prev_rdy <= o_rx_ready;
      if (o_rx_ready && !prev_rdy) begin
         rdy_rises <= rdy_rises + 1;
         rise_cyc  <= cyc;
      end
      if (o_rx_frame_err) ferr_cyc <= ferr_cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   // Start frames on a fixed residue of the cycle counter so the phase of the
   // free-running tick, and hence completion latency, repeats frame to frame.
   task automatic align();
      do wait_clks(1); while (cyc % DIV != 0);
   endtask

   task automatic send_now(input logic [7:0] d, input int stop_low);
      i_rx = 1'b0;
      wait_clks(BIT);
      for (int i = 0; i < 8; i++) begin
         i_rx = d[i];
         wait_clks(BIT);
      end
      if (stop_low > 0) begin
         i_rx = 1'b0;
         wait_clks(stop_low);
      end
      i_rx = 1'b1;
      wait_clks(BIT - stop_low);
   endtask

   task automatic send_frame(input logic [7:0] d, input int stop_low, output int s);
      align();
      s = cyc;
      send_now(d, stop_low);
   endtask

   task automatic pulse_clear();
      i_rx_clear = 1'b1;
      wait_clks(1);
      i_rx_clear = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         s;
      int         r0;
      int         f0;
      int         lat;
      logic [7:0] add_w [4];
      logic [7:0] d;

      add_w = '{8'h00, 8'h23, 8'h00, 8'h20};

      // Reset for 100 ns
      wait_clks(10);
      chk("rst_data",  o_rx_data,      0);
      chk("rst_ready", o_rx_ready,     0);
      chk("rst_ferr",  o_rx_frame_err, 0);
      chk("rst_ovr",   o_rx_overrun,   0);
      i_reset = 1'b0;
      wait_clks(3);
      chk("idle_ready", o_rx_ready, 0);

      // Single frame 0x64, then clear
      send_frame(8'h64, 0, s);
      chk("t1_data",  o_rx_data,    8'h64);
      chk("t1_ready", o_rx_ready,   1);
      chk("t1_ferr",  ferr_cyc,     0);
      chk("t1_ovr",   o_rx_overrun, 0);
      pulse_clear();
      chk("t1_clr_ready", o_rx_ready, 0);
      chk("t1_clr_data",  o_rx_data,  8'h64);

      // ADD word, clearing after each byte
      r0 = rdy_rises;
      for (int i = 0; i < 4; i++) begin
         send_frame(add_w[i], 0, s);
         chk($sformatf("t2_data%0d", i),  o_rx_data,  add_w[i]);
         chk($sformatf("t2_ready%0d", i), o_rx_ready, 1);
         pulse_clear();
      end
      chk("t2_rises", rdy_rises - r0, 4);
      chk("t2_ovr",   o_rx_overrun,   0);

      // Overrun, then clear coincident with completion
      r0 = rdy_rises;
      send_frame(8'hFF, 0, s);
      lat = rise_cyc - s;
      chk("t3_one_rise", rdy_rises - r0, 1);
      chk("t3_latency_window", (lat >= LAT_NOM - LAT_TOL) && (lat <= LAT_NOM + LAT_TOL), 1);
      if (lat < LAT_NOM - LAT_TOL || lat > LAT_NOM + LAT_TOL) lat = LAT_NOM;
      chk("t3_data_ff", o_rx_data,    8'hFF);
      chk("t3_ovr0",    o_rx_overrun, 0);
      send_frame(8'h63, 0, s);
      chk("t3_data_63", o_rx_data,    8'h63);
      chk("t3_ready",   o_rx_ready,   1);
      chk("t3_ovr1",    o_rx_overrun, 1);
      align();
      s = cyc;
      fork
         send_now(8'h3A, 0);
         begin
            while (cyc < s + lat - 1) wait_clks(1);
            i_rx_clear = 1'b1;
            wait_clks(1);
            i_rx_clear = 1'b0;
         end
      join
      chk("t3_sim_data",  o_rx_data,    8'h3A);
      chk("t3_sim_ready", o_rx_ready,   1);
      chk("t3_sim_ovr",   o_rx_overrun, 0);
      pulse_clear();

      // Short low glitch on idle line, then 0xA5
      f0 = ferr_cyc;
      r0 = rdy_rises;
      i_rx = 1'b0;
      wait_clks(50);
      i_rx = 1'b1;
      wait_clks(300);
      chk("t4_glitch_ready", o_rx_ready,     0);
      chk("t4_glitch_rises", rdy_rises - r0, 0);
      chk("t4_glitch_ferr",  ferr_cyc - f0,  0);
      send_frame(8'hA5, 0, s);
      chk("t4_data",  o_rx_data,  8'hA5);
      chk("t4_ready", o_rx_ready, 1);
      pulse_clear();

      // Stop bit low across its sampling point
      f0 = ferr_cyc;
      send_frame(8'h55, 100, s);
      chk("t5_ferr_once", ferr_cyc - f0, 1);
      chk("t5_ready",     o_rx_ready,    0);
      chk("t5_data",      o_rx_data,     8'hA5);
      wait_clks(2 * BIT);
      chk("t5_ready_late", o_rx_ready, 0);

      // Reset during data bit 4 of 0x3C, then 0xC3
      d = 8'h3C;
      align();
      i_rx = 1'b0;
      wait_clks(BIT);
      for (int i = 0; i < 4; i++) begin
         i_rx = d[i];
         wait_clks(BIT);
      end
      i_rx = d[4];
      wait_clks(BIT / 2);
      i_reset = 1'b1;
      wait_clks(2);
      chk("t6_rst_data",  o_rx_data,      0);
      chk("t6_rst_ready", o_rx_ready,     0);
      chk("t6_rst_ovr",   o_rx_overrun,   0);
      chk("t6_rst_ferr",  o_rx_frame_err, 0);
      i_rx = 1'b1;
      wait_clks(3);
      i_reset = 1'b0;
      wait_clks(200);
      chk("t6_idle_ready", o_rx_ready, 0);
      send_frame(8'hC3, 0, s);
      chk("t6_data",  o_rx_data,    8'hC3);
      chk("t6_ready", o_rx_ready,   1);
      chk("t6_ovr",   o_rx_overrun, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
